cpu_instr_feeder: RTL and testbench



---
 rtl/cpu_instr_feeder.sv | 153 +++++++++++++++
 tb/tb_cpu_instr_feeder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_instr_feeder.sv
// Instruction feeder for the cpu block: host-filled circular FIFO plus a small
// issue FSM that loads one instruction, starts the cpu and waits for its w
// handshake (fall, then rise). Counts retirements and halts on a hang.
module cpu_instr_feeder #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [15:0]   wr_data,
  input  logic          run,
  input  logic          cpu_w,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  output logic          full,
  output logic [AW:0]   count,
  output logic          busy,
  output logic [7:0]    retired,
  output logic          overflow,
  output logic          timeout_err
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitBusy,
    StWaitDone,
    StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic [15:0]      mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q;
  logic [15:0]      cpu_in_q;
  logic             cpu_load_q, cpu_s_q;
  logic [7:0]       retired_q;
  logic             overflow_q, timeout_q;
  logic             push_ok, pop, retire, fire;

  assign full     = (count_q == (AW + 1)'(DEPTH));
  assign push_ok  = wr_en && !full;
  // The pop is taken at the end of the LOAD cycle; cpu_in was captured on entry.
  assign pop      = (state_q == StLoad);
  assign busy     = (state_q != StIdle);

  assign cpu_in      = cpu_in_q;
  assign cpu_load    = cpu_load_q;
  assign cpu_s       = cpu_s_q;
  assign count       = count_q;
  assign retired     = retired_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;

  // Next-state logic and watchdog; forward progress wins over a same-cycle expiry.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    retire  = 1'b0;
    fire    = 1'b0;
    case (state_q)
      StIdle: begin
        if (run && (count_q != '0) && cpu_w) state_d = StLoad;
      end
      StLoad: state_d = StStart;
      StStart: begin
        state_d = StWaitBusy;
        wd_d    = '0;
      end
      StWaitBusy: begin
        if (!cpu_w) begin
          state_d = StWaitDone;
          wd_d    = '0;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          fire    = 1'b1;
          state_d = StHalt;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (cpu_w) begin
          retire  = 1'b1;
          state_d = StIdle;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          fire    = 1'b1;
          state_d = StHalt;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // FSM state and watchdog registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (wr_en && full) overflow_q <= 1'b1;
    end
  end

  // Registered cpu strobes reflect the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_in_q   <= 16'h0000;
      cpu_load_q <= 1'b0;
      cpu_s_q    <= 1'b0;
      retired_q  <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      cpu_load_q <= (state_d == StLoad);
      cpu_s_q    <= (state_d == StStart) || (state_d == StWaitBusy);
      if (state_q == StIdle && state_d == StLoad) cpu_in_q <= mem_q[rd_ptr_q];
      if (retire) retired_q <= retired_q + 8'd1;
      if (fire)   timeout_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_instr_feeder.sv
// Scoreboard bench for cpu_instr_feeder with a behavioural cpu handshake model.
module tb_cpu_instr_feeder;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        run = 1'b0;
  logic        cpu_w = 1'b1;
  logic [15:0] cpu_in;
  logic        cpu_load, cpu_s, full, busy, overflow, timeout_err;
  logic [3:0]  count;
  logic [7:0]  retired;

  cpu_instr_feeder #(.DEPTH(8), .AW(3), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .run(run),
    .cpu_w(cpu_w), .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s),
    .full(full), .count(count), .busy(busy), .retired(retired),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO order as a queue, sticky overflow, retirement tally.
  logic [15:0] exp_q[$];
  bit          exp_ovf = 1'b0;
  int          exp_retired = 0;
  bit          hang = 1'b0;
  bit          s_prev = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expire(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait budget expired", name);
  endtask

  // cpu model: w falls 2 cycles after s is seen, rises 4 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && cpu_s && cpu_w && !hang) begin
        repeat (2) @(negedge clk);
        cpu_w = 1'b0;
        repeat (4) @(negedge clk);
        cpu_w = 1'b1;
        if (!reset) exp_retired++;
      end
    end
  end

  // Monitor: every load must present the oldest outstanding accepted word.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (cpu_load) begin
          if (exp_q.size() == 0) expire("unexpected_load");
          else check("cpu_in_order", int'(cpu_in), int'(exp_q.pop_front()));
        end
        if (s_prev && !cpu_s && !timeout_err) check("s_held_until_w_low", int'(cpu_w), 0);
      end
      s_prev = cpu_s;
    end
  end

  task automatic push(input logic [15:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else exp_ovf = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    exp_ovf     = 1'b0;
    exp_retired = 0;
    reset       = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    run = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(count == 0 && !busy && exp_q.size() == 0) && n < 600);
    if (n >= 600) expire({name, "_drain"});
    @(negedge clk);
    check({name, "_retired"}, int'(retired), exp_retired & 8'hFF);
    check({name, "_count"}, int'(count), 0);
    check({name, "_busy"}, int'(busy), 0);
  endtask

  task automatic wait_s(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_s && n < 100);
    if (!cpu_s) expire(name);
  endtask

  task automatic wait_load(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_load && n < 100);
    if (!cpu_load) expire(name);
  endtask

  initial begin
    logic [15:0] d;
    int n;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cpu_in", int'(cpu_in), 0);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_strobes", int'({cpu_load, cpu_s, overflow, timeout_err, full}), 0);

    // Two real instructions through a cooperative cpu.
    push(16'hD007);
    push(16'hD102);
    drain("two_instr");
    run = 1'b0;

    // Overflow with run low, then issue order across a pointer wrap.
    for (int i = 0; i < 9; i++) push(16'($urandom));
    @(negedge clk);
    check("ovf_count", int'(count), int'(exp_q.size()));
    check("ovf_full", int'(full), 1);
    check("ovf_flag", int'(overflow), int'(exp_ovf));
    drain("ovf_drain");
    run = 1'b0;
    for (int i = 0; i < 8; i++) push(16'($urandom));
    @(negedge clk);
    check("wrap_full", int'(full), 1);
    drain("wrap_drain");
    run = 1'b0;

    // Asynchronous reset in WAIT_DONE with three entries still queued.
    for (int i = 0; i < 4; i++) push(16'h8000 | 16'($urandom));
    run = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && !cpu_s && !cpu_load && count == 3) && n < 100);
    if (n >= 100) expire("reach_wait_done");
    #2 reset = 1'b1;
    #1;
    check("async_cpu_in", int'(cpu_in), 0);
    check("async_count", int'(count), 0);
    check("async_busy", int'(busy), 0);
    check("async_retired", int'(retired), 0);
    check("async_flags", int'({cpu_load, cpu_s, overflow, timeout_err, full}), 0);
    run = 1'b0;
    repeat (30) @(negedge clk);
    exp_q.delete();
    exp_ovf     = 1'b0;
    exp_retired = 0;
    reset       = 1'b0;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_count", int'(count), 0);

    // Dropping run mid-instruction lets it finish and then holds.
    for (int i = 0; i < 3; i++) push(16'($urandom));
    run = 1'b1;
    wait_s("run_drop_s");
    run = 1'b0;
    repeat (40) @(negedge clk);
    check("run_drop_retired", int'(retired), exp_retired);
    check("run_drop_count", int'(count), 2);
    check("run_drop_busy", int'(busy), 0);
    drain("run_resume");
    run = 1'b0;

    // Push coinciding with the LOAD pop: full rejects, partial keeps count.
    do_reset();
    for (int i = 0; i < 8; i++) push(16'($urandom));
    run = 1'b1;
    wait_load("pop_full_load");
    wr_en   = 1'b1;
    wr_data = 16'($urandom);
    exp_ovf = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("pop_full_count", int'(count), 7);
    check("pop_full_ovf", int'(overflow), int'(exp_ovf));
    drain("pop_full_drain");
    run = 1'b0;
    for (int i = 0; i < 4; i++) push(16'($urandom));
    run = 1'b1;
    wait_load("pop_part_load");
    d       = 16'($urandom);
    wr_en   = 1'b1;
    wr_data = d;
    exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
    check("pop_part_count", int'(count), 4);
    drain("pop_part_drain");
    run = 1'b0;

    // Hung cpu: watchdog halts after TIMEOUT cycles in WAIT_BUSY.
    do_reset();
    hang = 1'b1;
    for (int i = 0; i < 3; i++) push(16'($urandom));
    run = 1'b1;
    wait_s("hang_s");
    repeat (10) @(negedge clk);
    check("wd_not_yet", int'(timeout_err), 0);
    repeat (11) @(negedge clk);
    check("wd_fired", int'(timeout_err), 1);
    check("wd_cpu_s", int'(cpu_s), 0);
    check("wd_halt_busy", int'(busy), 1);
    check("wd_count", int'(count), 2);
    check("wd_retired", int'(retired), 0);
    repeat (20) @(negedge clk);
    check("wd_no_issue", int'(count), 2);
    hang = 1'b0;
    run  = 1'b0;
    do_reset();
    @(negedge clk);
    check("wd_reset_clear", int'(timeout_err), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
